// File: rtl/dp_sram_pkg.sv
// Shared FSM state type and read-latency constant for the dual-port SRAM arbiter.
// Defining DP_SRAM_OUT_REG_EN adds one output register stage (latency 2 instead of 1).
package dp_sram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

`ifdef DP_SRAM_OUT_REG_EN
  localparam int RD_LATENCY = 2;
`else
  localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/dp_sram_port.sv
// One SRAM access port: request acceptance, range check, read-data/valid/err pipeline.
// Latency RD_LATENCY; never stalls, requests are ignored while ready_i is low (DP_SRAM_OUT_REG_EN adds a stage).
module dp_sram_port
  import dp_sram_pkg::*;
#(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 64,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 ready_i,
  input  logic                 en_i,
  input  logic                 rwenable_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [RAM_WIDTH-1:0] rdata_i,
  output logic                 mem_acc_o,
  output logic                 mem_wr_o,
  output logic [RAM_WIDTH-1:0] data_o,
  output logic                 valid_o,
  output logic                 err_o
);

  logic                 acc, in_range, rd;
  logic                 valid1_q, valid1_d, err1_q, err1_d;
  logic [RAM_WIDTH-1:0] data1_q, data1_d;

  // Extra bit keeps the compare correct when RAM_DEPTH == 2**ADDR_SIZE.
  assign in_range  = ({1'b0, addr_i} < (ADDR_SIZE + 1)'(RAM_DEPTH));
  assign acc       = en_i & ready_i;
  assign rd        = acc & ~rwenable_i;
  assign mem_acc_o = acc & in_range;
  assign mem_wr_o  = mem_acc_o & rwenable_i;

  always_comb begin
    valid1_d = rd;
    err1_d   = acc & ~in_range;
    data1_d  = data1_q;
    if (rd) data1_d = in_range ? rdata_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid1_q <= 1'b0;
      err1_q   <= 1'b0;
      data1_q  <= '0;
    end else begin
      valid1_q <= valid1_d;
      err1_q   <= err1_d;
      data1_q  <= data1_d;
    end
  end

`ifdef DP_SRAM_OUT_REG_EN
  logic                 valid2_q, err2_q;
  logic [RAM_WIDTH-1:0] data2_q, data2_d;

  assign data2_d = valid1_q ? data1_q : data2_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid2_q <= 1'b0;
      err2_q   <= 1'b0;
      data2_q  <= '0;
    end else begin
      valid2_q <= valid1_q;
      err2_q   <= err1_q;
      data2_q  <= data2_d;
    end
  end

  assign data_o  = data2_q;
  assign valid_o = valid2_q;
  assign err_o   = err2_q;
`else
  assign data_o  = data1_q;
  assign valid_o = valid1_q;
  assign err_o   = err1_q;
`endif

endmodule

// File: rtl/dp_sram_arb.sv
// Dual-port SRAM with zero-fill INIT, read-first access and A-wins write arbitration; read latency RD_LATENCY.
// Both ports accept every cycle in RUN (ready low during INIT/reset); DP_SRAM_OUT_REG_EN adds one output stage.
module dp_sram_arb
  import dp_sram_pkg::*;
#(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 64,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en_A,
  input  logic                 en_B,
  input  logic                 rwenable_A,
  input  logic                 rwenable_B,
  input  logic [ADDR_SIZE-1:0] addr_A,
  input  logic [ADDR_SIZE-1:0] addr_B,
  input  logic [RAM_WIDTH-1:0] data_A,
  input  logic [RAM_WIDTH-1:0] data_B,
  output logic                 ready_A,
  output logic                 ready_B,
  output logic [RAM_WIDTH-1:0] outputData_A,
  output logic [RAM_WIDTH-1:0] outputData_B,
  output logic                 valid_A,
  output logic                 valid_B,
  output logic                 err_A,
  output logic                 err_B,
  output logic                 collision
);

  localparam int IW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  state_e               state_q, state_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic                 clr_en, ready;
  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [IW-1:0]        idx_A, idx_B;
  logic [RAM_WIDTH-1:0] rdata_A, rdata_B;
  logic                 acc_A, acc_B, wr_A, wr_B, same_addr, coll_d, coll_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      INIT: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IW'(RAM_DEPTH - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready   = reset_n && (state_q == RUN);
  assign ready_A = ready;
  assign ready_B = ready;

  assign idx_A     = addr_A[IW-1:0];
  assign idx_B     = addr_B[IW-1:0];
  assign rdata_A   = mem_q[idx_A];
  assign rdata_B   = mem_q[idx_B];
  assign same_addr = (addr_A == addr_B);

  // Port A is written last so it wins a same-address write; reads see pre-edge contents.
  always_ff @(posedge clk) begin
    if (reset_n && clr_en) mem_q[cnt_q] <= '0;
    if (wr_B && !(wr_A && same_addr)) mem_q[idx_B] <= data_B;
    if (wr_A) mem_q[idx_A] <= data_A;
  end

  assign coll_d = acc_A & acc_B & same_addr & (wr_A | wr_B);

  always_ff @(posedge clk) begin
    if (!reset_n) coll_q <= 1'b0;
    else          coll_q <= coll_d;
  end

`ifdef DP_SRAM_OUT_REG_EN
  logic coll2_q;
  always_ff @(posedge clk) begin
    if (!reset_n) coll2_q <= 1'b0;
    else          coll2_q <= coll_q;
  end
  assign collision = coll2_q;
`else
  assign collision = coll_q;
`endif

  dp_sram_port #(
    .RAM_WIDTH(RAM_WIDTH),
    .RAM_DEPTH(RAM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_port_a (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .ready_i   (ready),
    .en_i      (en_A),
    .rwenable_i(rwenable_A),
    .addr_i    (addr_A),
    .rdata_i   (rdata_A),
    .mem_acc_o (acc_A),
    .mem_wr_o  (wr_A),
    .data_o    (outputData_A),
    .valid_o   (valid_A),
    .err_o     (err_A)
  );

  dp_sram_port #(
    .RAM_WIDTH(RAM_WIDTH),
    .RAM_DEPTH(RAM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_port_b (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .ready_i   (ready),
    .en_i      (en_B),
    .rwenable_i(rwenable_B),
    .addr_i    (addr_B),
    .rdata_i   (rdata_B),
    .mem_acc_o (acc_B),
    .mem_wr_o  (wr_B),
    .data_o    (outputData_B),
    .valid_o   (valid_B),
    .err_o     (err_B)
  );

endmodule

// File: tb/tb_dp_sram_arb.sv
// Bench for dp_sram_arb: behavioural memory model checked every cycle plus literal scenario checks.
module tb_dp_sram_arb;
  import dp_sram_pkg::*;

  localparam int W   = 8;
  localparam int D   = 64;
  localparam int AS  = 8;
  localparam int LAT = RD_LATENCY;

  logic          clk = 1'b0;
  logic          reset_n, en_A, en_B, rwenable_A, rwenable_B;
  logic [AS-1:0] addr_A, addr_B;
  logic [W-1:0]  data_A, data_B;
  logic          ready_A, ready_B, valid_A, valid_B, err_A, err_B, collision;
  logic [W-1:0]  outputData_A, outputData_B;

  always #5 clk = ~clk;

  dp_sram_arb #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_SIZE(AS)) dut (
    .clk(clk), .reset_n(reset_n),
    .en_A(en_A), .en_B(en_B),
    .rwenable_A(rwenable_A), .rwenable_B(rwenable_B),
    .addr_A(addr_A), .addr_B(addr_B),
    .data_A(data_A), .data_B(data_B),
    .ready_A(ready_A), .ready_B(ready_B),
    .outputData_A(outputData_A), .outputData_B(outputData_B),
    .valid_A(valid_A), .valid_B(valid_B),
    .err_A(err_A), .err_B(err_B),
    .collision(collision)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: memory contents, INIT progress, and per-edge results aged by LAT edges.
  int m_mem [D];
  bit m_run;
  int m_cnt;
  bit pvA [2], pvB [2], peA [2], peB [2], pc [2];
  int pdA [2], pdB [2];
  int edA, edB;

  task automatic model_edge();
    bit accA, accB, inA, inB;
    if (!reset_n) begin
      m_run = 0; m_cnt = 0; edA = 0; edB = 0;
      for (int i = 0; i < 2; i++) begin
        pvA[i] = 0; pvB[i] = 0; peA[i] = 0; peB[i] = 0; pc[i] = 0; pdA[i] = 0; pdB[i] = 0;
      end
      for (int i = 0; i < D; i++) m_mem[i] = 0;
      return;
    end
    accA = en_A && m_run;
    accB = en_B && m_run;
    inA  = int'(addr_A) < D;
    inB  = int'(addr_B) < D;
    pvA[1] = pvA[0]; pvB[1] = pvB[0]; peA[1] = peA[0]; peB[1] = peB[0];
    pc[1]  = pc[0];  pdA[1] = pdA[0]; pdB[1] = pdB[0];
    pvA[0] = accA && !rwenable_A;
    pvB[0] = accB && !rwenable_B;
    peA[0] = accA && !inA;
    peB[0] = accB && !inB;
    pdA[0] = (pvA[0] && inA) ? m_mem[addr_A] : 0;
    pdB[0] = (pvB[0] && inB) ? m_mem[addr_B] : 0;
    pc[0]  = accA && accB && inA && inB && (addr_A == addr_B) && (rwenable_A || rwenable_B);
    if (accB && rwenable_B && inB) m_mem[addr_B] = data_B;
    if (accA && rwenable_A && inA) m_mem[addr_A] = data_A;
    if (pvA[LAT-1]) edA = pdA[LAT-1];
    if (pvB[LAT-1]) edB = pdB[LAT-1];
    if (!m_run) begin
      m_cnt++;
      if (m_cnt == D) m_run = 1;
    end
  endtask

  task automatic compare();
    chk("ready_A", ready_A, reset_n && m_run);
    chk("ready_B", ready_B, reset_n && m_run);
    chk("valid_A", valid_A, pvA[LAT-1]);
    chk("valid_B", valid_B, pvB[LAT-1]);
    chk("err_A", err_A, peA[LAT-1]);
    chk("err_B", err_B, peB[LAT-1]);
    chk("collision", collision, pc[LAT-1]);
    chk("outputData_A", outputData_A, edA);
    chk("outputData_B", outputData_B, edB);
  endtask

  task automatic cycle(input int rst, input int eA, input int rwA, input int aA, input int dA,
                       input int eB, input int rwB, input int aB, input int dB);
    reset_n    = rst[0];
    en_A       = eA[0];  rwenable_A = rwA[0]; addr_A = aA[AS-1:0]; data_A = dA[W-1:0];
    en_B       = eB[0];  rwenable_B = rwB[0]; addr_B = aB[AS-1:0]; data_B = dB[W-1:0];
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    for (int i = 1; i < LAT; i++) idle();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_A && n < 300) begin
      idle();
      n++;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 10, 0, 1, 0, 11, 0);
    chk("rst_ready_A", ready_A, 0);
    chk("rst_valid_A", valid_A, 0);
    chk("rst_data_A", outputData_A, 0);
    chk("rst_collision", collision, 0);

    wait_ready(n);
    chk("init_cycles", n, 64);

    cycle(1, 1, 0, 10, 0, 0, 0, 0, 0); settle();
    chk("rd10_valid", valid_A, 1);
    chk("rd10_data", outputData_A, 0);

    cycle(1, 1, 1, 1, 16, 1, 1, 5, 20);
    cycle(1, 1, 0, 5, 0, 1, 0, 1, 0); settle();
    chk("xrd_A", outputData_A, 20);
    chk("xrd_B", outputData_B, 16);
    chk("xrd_valid_B", valid_B, 1);

    cycle(1, 1, 1, 3, 'hAA, 1, 1, 3, 'h55); settle();
    chk("ww_collision", collision, 1);
    idle();
    chk("ww_collision_once", collision, 0);
    cycle(1, 1, 0, 3, 0, 0, 0, 0, 0); settle();
    chk("ww_A_wins", outputData_A, 'hAA);

    cycle(1, 1, 1, 3, 'h11, 1, 0, 3, 0); settle();
    chk("rw_old_data", outputData_B, 'hAA);
    chk("rw_collision", collision, 1);
    cycle(1, 0, 0, 0, 0, 1, 0, 3, 0); settle();
    chk("rw_new_data", outputData_B, 'h11);

    cycle(1, 1, 0, 4, 0, 1, 0, 4, 0); settle();
    chk("rr_no_collision", collision, 0);

    cycle(1, 1, 0, 70, 0, 0, 0, 0, 0); settle();
    chk("oor_valid", valid_A, 1);
    chk("oor_data", outputData_A, 0);
    chk("oor_err", err_A, 1);
    cycle(1, 1, 1, 70, 'hFF, 0, 0, 0, 0);
    cycle(1, 1, 0, 6, 0, 0, 0, 0, 0); settle();
    chk("oor_wr_alias", outputData_A, 0);
    for (int i = 0; i < D; i++) cycle(1, 1, 0, i, 0, 1, 0, D - 1 - i, 0);
    settle();

    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 499) != 0) ? 1 : 0,
            $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0) ? $urandom_range(64, 255) : $urandom_range(0, 7),
            $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0) ? $urandom_range(64, 255) : $urandom_range(0, 7),
            $urandom_range(0, 255));
    end

    wait_ready(n);
    chk("rand_recover", ready_A, 1);
    cycle(1, 1, 1, 2, 'h77, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 2, 0, 1, 0, 2, 0);
    cycle(0, 1, 0, 2, 0, 1, 0, 2, 0);
    chk("rst_abort_valid", valid_A, 0);
    cycle(0, 1, 0, 2, 0, 1, 0, 2, 0);
    chk("rst_abort_valid2", valid_B, 0);
    chk("rst_abort_data", outputData_A, 0);
    wait_ready(n);
    chk("reinit_cycles", n, 64);
    cycle(1, 1, 0, 2, 0, 0, 0, 0, 0); settle();
    chk("reinit_cleared", outputData_A, 0);
    chk("reinit_valid", valid_A, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dp_sram_arb.md
DP_SRAM_ARB -- requirements
Module: dp_sram_arb

Interface
REQ-001 The block SHALL have parameter RAM_WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter RAM_DEPTH, default 64, number of words (>=2).
REQ-003 The block SHALL have parameter ADDR_SIZE, default 8, address width (2**ADDR_SIZE >= RAM_DEPTH).
REQ-004 Port clk  input  1  sole clock, all logic on rising edge.
REQ-005 Port reset_n  input  1  synchronous, active-low reset.
REQ-006 Ports en_A / en_B  input  1  request valid per port.
REQ-007 Ports rwenable_A / rwenable_B  input  1  1 = write, 0 = read.
REQ-008 Ports addr_A / addr_B  input  ADDR_SIZE  word address.
REQ-009 Ports data_A / data_B  input  RAM_WIDTH  write data.
REQ-010 Ports ready_A / ready_B  output  1  block accepts requests this cycle.
REQ-011 Ports outputData_A / outputData_B  output  RAM_WIDTH  read data.
REQ-012 Ports valid_A / valid_B  output  1  outputData_X holds read data this cycle.
REQ-013 Ports err_A / err_B  output  1  one-cycle pulse, accepted request had addr >= RAM_DEPTH.
REQ-014 Port collision  output  1  one-cycle pulse, same-address conflict arbitrated.

Function
REQ-015 The FSM SHALL have states INIT and RUN; INIT clears word 0..RAM_DEPTH-1 to zero, one word per cycle via an internal counter, then moves to RUN (INIT lasts exactly RAM_DEPTH cycles).
REQ-016 ready_A and ready_B SHALL be 0 in INIT and 1 in RUN; requests with ready low are ignored.
REQ-017 A request is accepted when en_X && ready_X at a rising edge.
REQ-018 An accepted write SHALL update memory at that edge; an accepted read SHALL drive outputData_X with valid_X = 1 exactly 1 cycle later (read latency 1).
REQ-019 When no read completes, valid_X SHALL be 0 and outputData_X SHALL hold its last value.
REQ-020 Reads SHALL be read-first: a read and a write to the same address in the same cycle (either port combination) returns the old data.
REQ-021 Both ports writing the same address in the same cycle: port A data SHALL be stored, port B write dropped, collision pulses for 1 cycle in the following cycle.
REQ-022 Read/write to same address on opposite ports SHALL also pulse collision; both reads to same address SHALL NOT.
REQ-023 Address >= RAM_DEPTH: write ignored, read returns zero with valid_X = 1, err_X pulses with the same timing as valid_X.
REQ-024 Back-to-back requests every cycle SHALL be sustained on both ports with no bubbles.

Reset
REQ-025 While reset_n = 0 at a rising edge: state <= INIT, init counter <= 0, outputData_A/B <= 0, valid_A/B <= 0, err_A/B <= 0, collision <= 0, ready_A/B = 0.
REQ-026 Reset asserted mid-INIT or mid-RUN SHALL abort all in-flight reads (no valid pulse) and restart a full INIT clear after release.

Configuration
REQ-027 Macro DP_SRAM_OUT_REG_EN defined: an extra output register stage SHALL be inserted; read latency 2 cycles; valid_X, err_X and collision delayed by one further cycle, pipeline cleared by reset.
REQ-028 Macro DP_SRAM_OUT_REG_EN undefined: read latency 1 cycle as REQ-018.

Structure
REQ-029 Package dp_sram_pkg SHALL hold the FSM state enum (INIT, RUN) and the latency constant derived from DP_SRAM_OUT_REG_EN.
REQ-030 Sub-module dp_sram_port SHALL be instantiated once per port: request acceptance, range check, read-data/valid/err pipeline.
REQ-031 Memory array, INIT FSM and collision arbitration SHALL live in dp_sram_arb.

Verification
REQ-032 Reset release, RAM_DEPTH=64 -> ready_A/B low 64 cycles, then high; read addr 10 -> outputData = 0, valid one cycle later.
REQ-033 Write A addr1=16 and B addr5=20 same cycle, then read A addr5 and B addr1 -> A sees 20, B sees 16, latency 1 (2 with DP_SRAM_OUT_REG_EN).
REQ-034 Both ports write addr 3 (A=0xAA, B=0x55) -> collision pulses once, later read addr 3 returns 0xAA.
REQ-035 Addr 3 holds 0xAA; A writes 0x11 to addr 3 while B reads addr 3 -> B gets 0xAA, collision pulses; next read returns 0x11.
REQ-036 Read addr 70 on A -> valid_A = 1, outputData_A = 0, err_A pulses; write addr 70 leaves all words unchanged.
REQ-037 Assert reset_n low during stream of reads -> no valid pulse after reset, INIT repeats, previously written data reads back 0.
